// File: rtl/display_hex_mux2.sv
// display_hex_mux2
//   Time-multiplexed driver for a 2-digit common 7-segment display.
//   An 8-bit value (two hex nibbles) is captured into a shadow register and
//   moved into the display register only at frame boundaries, so a frame is
//   never torn. Each digit slot opens with a dead-time blank to avoid ghosting.
//
// Ports
//   clock_50mhz  in   1  system clock (single domain)
//   reset_n      in   1  asynchronous reset, active-low
//   valor        in   8  [3:0] digit 0 (anodos[0]), [7:4] digit 1 (anodos[1])
//   valor_valid  in   1  1-cycle load strobe for valor
//   blank_en     in   1  force display dark; scan keeps running
//   segmentos    out  7  segment drive, bit0=a .. bit6=g
//   anodos       out  2  digit enables, one-hot when lit
//   frame_tick   out  1  1-cycle pulse at the start of each frame

module display_hex_mux2 #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int REFRESH_HZ     = 1_000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clock_50mhz,
  input  logic       reset_n,
  input  logic [7:0] valor,
  input  logic       valor_valid,
  input  logic       blank_en,
  output logic [6:0] segmentos,
  output logic [1:0] anodos,
  output logic       frame_tick
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [6:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]       AN_OFF     = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    LIT0   = 2'd1,
    BLANK1 = 2'd2,
    LIT1   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       shadow, disp;
  logic             pending;
  logic             slot_end, blank_end, frame_end;
  logic [6:0]       seg_raw, seg_nx;
  logic [1:0]       an_raw, an_nx;

  // Active-high gfedcba patterns
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Slot counter runs 0..DIV-1 across each slot; the blank phase is its
  // first BLANK_CYCLES counts. ">=" keeps a corrupted counter from running
  // past the slot end.
  always_comb begin
    slot_end  = (cnt >= CNT_LAST);
    blank_end = (cnt == BLANK_LAST);
    cnt_nx    = slot_end ? '0 : cnt + 1'b1;
    state_nx  = state;
    case (state)
      BLANK0:  if (blank_end) state_nx = LIT0;
      LIT0:    if (slot_end)  state_nx = BLANK1;
      BLANK1:  if (blank_end) state_nx = LIT1;
      LIT1:    if (slot_end)  state_nx = BLANK0;
      default: begin
        state_nx = BLANK0;
        cnt_nx   = '0;
      end
    endcase
    frame_end = (state == LIT1) && slot_end;
  end

  // Outputs are derived from the next state so they change on the same edge
  // as the state register. disp is stable whenever a LIT state is entered,
  // because transfers only happen on the edge into BLANK0.
  always_comb begin
    seg_raw = 7'h00;
    an_raw  = 2'b00;
    if (!blank_en) begin
      case (state_nx)
        LIT0: begin
          an_raw  = 2'b01;
          seg_raw = hex7(disp[3:0]);
        end
        LIT1: begin
          an_raw  = 2'b10;
          seg_raw = hex7(disp[7:4]);
        end
        default: begin
          an_raw  = 2'b00;
          seg_raw = 7'h00;
        end
      endcase
    end
    seg_nx = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_nx  = AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
  end

  // Scan FSM, tear-free load path and registered outputs.
  // A strobe landing on the frame edge bypasses the shadow straight into disp.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BLANK0;
      cnt        <= '0;
      shadow     <= 8'h00;
      disp       <= 8'h00;
      pending    <= 1'b0;
      segmentos  <= SEG_OFF;
      anodos     <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      segmentos  <= seg_nx;
      anodos     <= an_nx;
      frame_tick <= frame_end;
      if (frame_end) begin
        if (valor_valid) begin
          disp   <= valor;
          shadow <= valor;
        end else if (pending) begin
          disp <= shadow;
        end
        pending <= 1'b0;
      end else if (valor_valid) begin
        shadow  <= valor;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_hex_mux2.sv
// tb_display_hex_mux2
//   Drives two display_hex_mux2 instances (active-high and active-low
//   polarity) with the same directed and random stimulus and compares every
//   cycle against a frame-position reference model.

module tb_display_hex_mux2;

  localparam int DIV   = 10;
  localparam int BC    = 2;
  localparam int FRAME = 2 * DIV;

  logic       clock_50mhz = 1'b0;
  logic       reset_n;
  logic [7:0] valor;
  logic       valor_valid;
  logic       blank_en;
  logic [6:0] seg_h, seg_l;
  logic [1:0] an_h, an_l;
  logic       tick_h, tick_l;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position in the frame plus the load/transfer registers
  int         t;
  logic [7:0] disp_m, shadow_m;
  logic       pending_m, blank_m;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clock_50mhz = ~clock_50mhz;

  display_hex_mux2 #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_h (
    .clock_50mhz(clock_50mhz), .reset_n(reset_n), .valor(valor),
    .valor_valid(valor_valid), .blank_en(blank_en),
    .segmentos(seg_h), .anodos(an_h), .frame_tick(tick_h)
  );

  display_hex_mux2 #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_l (
    .clock_50mhz(clock_50mhz), .reset_n(reset_n), .valor(valor),
    .valor_valid(valor_valid), .blank_en(blank_en),
    .segmentos(seg_l), .anodos(an_l), .frame_tick(tick_l)
  );

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
    end
  endtask

  task automatic checkOutput();
    int         pos;
    logic       lit0, lit1;
    logic [7:0] e_seg, e_an, e_tick;
    pos    = t % FRAME;
    lit0   = (pos >= BC) && (pos < DIV);
    lit1   = (pos >= DIV + BC);
    e_seg  = 8'h00;
    e_an   = 8'h00;
    if (!blank_m && lit0) begin
      e_an  = 8'h01;
      e_seg = {1'b0, hex_tab[disp_m[3:0]]};
    end else if (!blank_m && lit1) begin
      e_an  = 8'h02;
      e_seg = {1'b0, hex_tab[disp_m[7:4]]};
    end
    e_tick = {7'b0, (pos == 0) && (t != 0)};
    check1("seg",    {1'b0, seg_h},  e_seg);
    check1("an",     {6'b0, an_h},   e_an);
    check1("tick",   {7'b0, tick_h}, e_tick);
    check1("seg_n",  {1'b0, seg_l},  e_seg ^ 8'h7F);
    check1("an_n",   {6'b0, an_l},   e_an ^ 8'h03);
    check1("tick_n", {7'b0, tick_l}, e_tick);
  endtask

  task automatic modelReset();
    t         = 0;
    disp_m    = 8'h00;
    shadow_m  = 8'h00;
    pending_m = 1'b0;
    blank_m   = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance model on the edge, check after it
  task automatic applyStimulus(input logic v, input logic [7:0] val, input logic b);
    valor_valid = v;
    valor       = val;
    blank_en    = b;
    @(posedge clock_50mhz);
    if (t % FRAME == FRAME - 1) begin
      if (v) begin
        disp_m   = val;
        shadow_m = val;
      end else if (pending_m) begin
        disp_m = shadow_m;
      end
      pending_m = 1'b0;
    end else if (v) begin
      shadow_m  = val;
      pending_m = 1'b1;
    end
    blank_m = b;
    t++;
    #1 checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic runTo(input int p);
    while (t % FRAME != p) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    valor       = 8'h00;
    valor_valid = 1'b0;
    blank_en    = 1'b0;
    modelReset();
    repeat (2) @(posedge clock_50mhz);
    #1 checkOutput();
    reset_n = 1'b1;

    $display("[TB] scan after reset, no loads");
    idle(41);

    $display("[TB] load 3A mid-LIT0");
    runTo(5);
    applyStimulus(1'b1, 8'h3A, 1'b0);
    idle(40);

    $display("[TB] two loads in one frame, last wins");
    runTo(3);
    applyStimulus(1'b1, 8'h12, 1'b0);
    idle(5);
    applyStimulus(1'b1, 8'h34, 1'b0);
    idle(40);

    $display("[TB] load E5 on the frame edge");
    runTo(FRAME - 1);
    applyStimulus(1'b1, 8'hE5, 1'b0);
    idle(20);

    $display("[TB] blank_en for 40 cycles");
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b1);
    idle(20);

    $display("[TB] random loads and blanking");
    repeat (400)
      applyStimulus($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
    idle(20);

    $display("[TB] reset mid-LIT1");
    runTo(14);
    #3 reset_n = 1'b0;
    modelReset();
    #1 checkOutput();
    @(posedge clock_50mhz);
    #1 checkOutput();
    reset_n = 1'b1;
    idle(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
